// File: rtl/swervolf_sevseg_scan_ctrl.sv
// Wishbone-mapped multiplexed seven-segment controller: per-digit enable, dp, blink,
// extended glyphs, PWM brightness and frame-synchronous shadow update of the display image.
module swervolf_sevseg_scan_ctrl #(
   parameter int N_DIGITS = 8,
   parameter int SCAN_W   = 17,
   parameter int BLINK_W  = 25
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [4:0]          i_wb_adr,
   input  logic [31:0]         i_wb_dat,
   input  logic [3:0]          i_wb_sel,
   input  logic                i_wb_we,
   input  logic                i_wb_cyc,
   input  logic                i_wb_stb,
   output logic [31:0]         o_wb_rdt,
   output logic                o_wb_ack,
   output logic [N_DIGITS-1:0] o_an,
   output logic [6:0]          o_seg,
   output logic                o_dp,
   output logic                o_frame_irq
);

   localparam logic [3:0] IDX_LAST = 4'(N_DIGITS - 1);

   function automatic logic [15:0] digit_mask();
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) m[i] = (i < N_DIGITS);
      return m;
   endfunction

   function automatic logic [63:0] nibble_mask();
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) m[4*i +: 4] = {4{i < N_DIGITS}};
      return m;
   endfunction

   localparam logic [15:0] DIG_MASK = digit_mask();
   localparam logic [63:0] NIB_MASK = nibble_mask();

   // Byte-lane merge of write data into a register, then drop bits of absent digits.
   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] dat,
                                         input logic [3:0] sel, input logic [31:0] mask);
      logic [31:0] m;
      m = cur;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) m[8*b +: 8] = dat[8*b +: 8];
      end
      return m & mask;
   endfunction

   // Segment order {a,b,c,d,e,f,g}, active-low.
   function automatic logic [6:0] decode(input logic [3:0] nib, input logic ext);
      logic [6:0] s;
      s = 7'h7F;
      if (!ext) begin
         case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
         endcase
      end else begin
         case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h5F;
            4'h2: s = 7'h6F;
            4'h3: s = 7'h77;
            4'h4: s = 7'h7B;
            4'h5: s = 7'h7D;
            4'h6: s = 7'h7E;
            4'h7: s = 7'h48;
            4'h8: s = 7'h71;
            4'h9: s = 7'h39;
            4'hA: s = 7'h79;
            4'hB: s = 7'h7A;
            default: s = 7'h7F;
         endcase
      end
      return s;
   endfunction

   logic [7:0]  ctrl;
   logic [31:0] enext;
   logic [63:0] dig;
   logic [31:0] dpblk;

   logic        disp_en, immediate, irq_en, blink_en;
   logic [3:0]  brightness;

   assign disp_en    = ctrl[0];
   assign immediate  = ctrl[1];
   assign irq_en     = ctrl[2];
   assign blink_en   = ctrl[3];
   assign brightness = ctrl[7:4];

   logic [15:0] sh_en, sh_ext, sh_dp, sh_blk;
   logic [63:0] sh_dig;

   logic [SCAN_W-1:0]  slot_cnt;
   logic [3:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_msb;
   logic               slot_wrap, idx_last, frame_wrap;

   assign blink_msb  = blink_cnt[BLINK_W-1];
   assign slot_wrap  = &slot_cnt;
   assign idx_last   = (idx == IDX_LAST);
   assign frame_wrap = slot_wrap & idx_last;

   // Bus request: one acknowledged beat, then at least one idle cycle before the next.
   logic       wb_req, wb_wr;
   logic [2:0] wb_word;

   assign wb_req  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
   assign wb_wr   = wb_req & i_wb_we;
   assign wb_word = i_wb_adr[4:2];

   logic [31:0] ctrl_wr, enext_wr, dig_lo_wr, dig_hi_wr, dpblk_wr;

   assign ctrl_wr   = merge({24'h0, ctrl}, i_wb_dat, i_wb_sel, 32'h0000_00FF);
   assign enext_wr  = merge(enext, i_wb_dat, i_wb_sel, {DIG_MASK, DIG_MASK});
   assign dig_lo_wr = merge(dig[31:0], i_wb_dat, i_wb_sel, NIB_MASK[31:0]);
   assign dig_hi_wr = merge(dig[63:32], i_wb_dat, i_wb_sel, NIB_MASK[63:32]);
   assign dpblk_wr  = merge(dpblk, i_wb_dat, i_wb_sel, {DIG_MASK, DIG_MASK});

   logic unused_bits;
   assign unused_bits = ^{i_wb_adr[1:0], ctrl_wr[31:8]};

   logic [31:0] rd_data;

   always_comb begin
      rd_data = 32'h0;
      case (wb_word)
         3'd0: rd_data = {24'h0, ctrl};
         3'd1: rd_data = enext;
         3'd2: rd_data = dig[31:0];
         3'd3: rd_data = dig[63:32];
         3'd4: rd_data = dpblk;
         3'd5: begin
            rd_data[3:0] = idx;
            rd_data[8]   = blink_msb;
         end
         default: rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_ack <= 1'b0;
         o_wb_rdt <= 32'h0;
         ctrl     <= 8'h0;
         enext    <= 32'h0;
         dig      <= 64'h0;
         dpblk    <= 32'h0;
      end else begin
         o_wb_ack <= wb_req;
         if (wb_req) o_wb_rdt <= rd_data;
         if (wb_wr) begin
            case (wb_word)
               3'd0: ctrl       <= ctrl_wr[7:0];
               3'd1: enext      <= enext_wr;
               3'd2: dig[31:0]  <= dig_lo_wr;
               3'd3: dig[63:32] <= dig_hi_wr;
               3'd4: dpblk      <= dpblk_wr;
               default: ;
            endcase
         end
      end
   end

   // Scan counters run regardless of disp_en so the frame timing never drifts.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         slot_cnt  <= '0;
         idx       <= 4'h0;
         blink_cnt <= '0;
      end else begin
         slot_cnt  <= slot_cnt + SCAN_W'(1);
         blink_cnt <= blink_cnt + BLINK_W'(1);
         if (slot_wrap) idx <= idx_last ? 4'h0 : idx + 4'h1;
      end
   end

   // The display image only changes at the frame seam unless immediate mode is on.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sh_en  <= 16'h0;
         sh_ext <= 16'h0;
         sh_dig <= 64'h0;
         sh_dp  <= 16'h0;
         sh_blk <= 16'h0;
      end else if (frame_wrap || immediate) begin
         sh_en  <= enext[15:0];
         sh_ext <= enext[31:16];
         sh_dig <= dig;
         sh_dp  <= dpblk[15:0];
         sh_blk <= dpblk[31:16];
      end
   end

   logic [3:0]          nib, phase;
   logic                lit;
   logic [N_DIGITS-1:0] an_nxt;
   logic [6:0]          seg_nxt;
   logic                dp_nxt;

   always_comb begin
      nib     = sh_dig[{idx, 2'b00} +: 4];
      phase   = slot_cnt[SCAN_W-1 -: 4];
      lit     = disp_en & sh_en[idx] & (phase <= brightness) &
                ~(blink_en & sh_blk[idx] & blink_msb);
      an_nxt  = '1;
      for (int i = 0; i < N_DIGITS; i++) an_nxt[i] = ~(lit & (idx == 4'(i)));
      seg_nxt = lit ? decode(nib, sh_ext[idx]) : 7'h7F;
      dp_nxt  = lit ? ~sh_dp[idx] : 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_an        <= '1;
         o_seg       <= 7'h7F;
         o_dp        <= 1'b1;
         o_frame_irq <= 1'b0;
      end else begin
         o_an        <= an_nxt;
         o_seg       <= seg_nxt;
         o_dp        <= dp_nxt;
         o_frame_irq <= frame_wrap & irq_en;
      end
   end

endmodule

// File: tb/tb_swervolf_sevseg_scan_ctrl.sv
// Bench for swervolf_sevseg_scan_ctrl at N_DIGITS=5, SCAN_W=4, BLINK_W=8 (80-cycle frame);
// the expected display is derived from cycles elapsed since reset and the register image written.
module tb_swervolf_sevseg_scan_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [4:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we, i_wb_cyc, i_wb_stb;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic [4:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp, o_frame_irq;

   swervolf_sevseg_scan_ctrl #(.N_DIGITS(5), .SCAN_W(4), .BLINK_W(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
      .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame_irq(o_frame_irq)
   );

   always #5 i_clk = ~i_clk;

   // Cycles since reset release: after edge n the scan state is slot n%16, digit (n/16)%5.
   int t;
   always @(posedge i_clk) begin
      if (i_rst) t <= 0;
      else t <= t + 1;
   end

   int n_vec = 0;
   int n_err = 0;
   int lit_cyc, irq_cnt;
   logic [13:0] exp_q[$];

   logic [7:0]  b_ctrl;
   logic [15:0] b_en, b_ext, b_dp, b_blk;
   logic [19:0] b_dig;

   localparam logic [4:0]  REG_ADR [6] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h18};
   localparam logic [31:0] REG_EXP [6] = '{32'h0000_00FF, 32'h001F_001F, 32'h000F_FFFF,
                                           32'h0, 32'h001F_001F, 32'h0};

   function automatic logic [6:0] glyph(input logic [3:0] v, input logic x);
      logic [6:0] g;
      g = 7'h7F;
      if (!x) begin
         case (v)
            0: g = 7'h01;  1: g = 7'h4F;  2: g = 7'h12;  3: g = 7'h06;
            4: g = 7'h4C;  5: g = 7'h24;  6: g = 7'h20;  7: g = 7'h0F;
            8: g = 7'h00;  9: g = 7'h04;  10: g = 7'h08; 11: g = 7'h60;
            12: g = 7'h31; 13: g = 7'h42; 14: g = 7'h30; default: g = 7'h38;
         endcase
      end else begin
         case (v)
            0: g = 7'h3F;  1: g = 7'h5F;  2: g = 7'h6F;  3: g = 7'h77;
            4: g = 7'h7B;  5: g = 7'h7D;  6: g = 7'h7E;  7: g = 7'h48;
            8: g = 7'h71;  9: g = 7'h39;  10: g = 7'h79; 11: g = 7'h7A;
            default: g = 7'h7F;
         endcase
      end
      return g;
   endfunction

   // Expected {irq, an, seg, dp} on the cycle after scan state s.
   function automatic logic [13:0] model_out(input int s);
      int slot, di;
      logic blk, lit, irq;
      logic [4:0] an;
      logic [6:0] seg;
      logic dp;
      slot = s % 16;
      di   = (s / 16) % 5;
      blk  = ((s >> 7) & 1) != 0;
      lit  = b_ctrl[0] && b_en[di] && (slot <= int'(b_ctrl[7:4])) &&
             !(b_ctrl[3] && b_blk[di] && blk);
      an   = lit ? ~(5'b00001 << di) : 5'h1F;
      seg  = lit ? glyph(b_dig[di*4 +: 4], b_ext[di]) : 7'h7F;
      dp   = lit ? ~b_dp[di] : 1'b1;
      irq  = b_ctrl[2] && (s % 80 == 79);
      return {irq, an, seg, dp};
   endfunction

   task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
      i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      @(negedge i_clk);
      n_vec++;
      if (o_wb_ack !== 1'b1) begin
         n_err++;
         $display("FAIL wr_ack adr=%h got %b want 1", adr, o_wb_ack);
      end
      i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic wb_read(input logic [4:0] adr, output logic [31:0] dat);
      i_wb_adr = adr; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      @(negedge i_clk);
      n_vec++;
      if (o_wb_ack !== 1'b1) begin
         n_err++;
         $display("FAIL rd_ack adr=%h got %b want 1", adr, o_wb_ack);
      end
      dat = o_wb_rdt;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      @(negedge i_clk);
      n_vec++;
      if (o_wb_ack !== 1'b0) begin
         n_err++;
         $display("FAIL ack_single adr=%h got %b want 0", adr, o_wb_ack);
      end
   endtask

   task automatic align_frame();
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while ((t % 80) != 0 && n < 200);
      if ((t % 80) != 0) begin
         n_vec++; n_err++;
         $display("FAIL align t=%0d got no frame start want one within 200 cycles", t);
      end
   endtask

   // Called on a negedge; one expected entry per scan state, compared one cycle later.
   task automatic observe(input int n);
      logic [13:0] e, g;
      exp_q.push_back(model_out(t));
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         g = {o_frame_irq, o_an, o_seg, o_dp};
         if (o_an !== 5'h1F) lit_cyc++;
         if (o_frame_irq === 1'b1) irq_cnt++;
         e = exp_q.pop_front();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL scan t=%0d got irq/an/seg/dp=%b/%h/%h/%b want %b/%h/%h/%b",
                     t, g[13], g[12:8], g[7:1], g[0], e[13], e[12:8], e[7:1], e[0]);
         end
         if (i < n - 1) exp_q.push_back(model_out(t));
      end
   endtask

   task automatic model_clear();
      b_ctrl = 8'h0; b_en = 16'h0; b_ext = 16'h0; b_dp = 16'h0; b_blk = 16'h0; b_dig = 20'h0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      n_vec++;
      if ({o_an, o_seg, o_dp, o_frame_irq, o_wb_ack} !== {5'h1F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_out got an=%h seg=%h dp=%b irq=%b ack=%b want 1f/7f/1/0/0",
                  o_an, o_seg, o_dp, o_frame_irq, o_wb_ack);
      end
      i_rst = 1'b0;
      model_clear();
      wb_read(5'h14, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want 0", d); end
      for (int i = 0; i < 5; i++) begin
         wb_read(REG_ADR[i], d);
         n_vec++;
         if (d !== 32'h0) begin n_err++; $display("FAIL reset_reg adr=%h got %h want 0", REG_ADR[i], d); end
      end
   endtask

   task automatic test_regs();
      logic [31:0] d;
      for (int i = 0; i < 6; i++) begin
         wb_write(REG_ADR[i], 32'hFFFF_FFFF, 4'hF);
         wb_read(REG_ADR[i], d);
         n_vec++;
         if (d !== REG_EXP[i]) begin n_err++; $display("FAIL reg_mask adr=%h got %h want %h", REG_ADR[i], d, REG_EXP[i]); end
      end
      wb_write(5'h08, 32'h0, 4'hF);
      wb_write(5'h08, 32'h1234_5678, 4'b0010);
      wb_write(5'h08, 32'hAABB_CCDD, 4'b0101);
      wb_read(5'h08, d);
      n_vec++;
      if (d !== 32'h000B_56DD) begin n_err++; $display("FAIL byte_lane_dig got %h want 000b56dd", d); end
      wb_write(5'h04, 32'h0, 4'hF);
      wb_write(5'h04, 32'hFFFF_FFFF, 4'b1100);
      wb_read(5'h04, d);
      n_vec++;
      if (d !== 32'h001F_0000) begin n_err++; $display("FAIL byte_lane_enext got %h want 001f0000", d); end
      wb_write(5'h00, 32'h0, 4'hF);
      wb_write(5'h04, 32'h0, 4'hF);
      wb_write(5'h08, 32'h0, 4'hF);
      wb_write(5'h10, 32'h0, 4'hF);
   endtask

   task automatic test_scan();
      logic [31:0] d, e;
      int tt;
      wb_write(5'h08, 32'h0004_3210, 4'hF);
      wb_write(5'h04, 32'h0000_001F, 4'hF);
      wb_write(5'h00, 32'h0000_00F1, 4'hF);
      b_ctrl = 8'hF1; b_en = 16'h1F; b_dig = 20'h43210;
      align_frame();
      observe(160);
      wb_read(5'h08, d);
      n_vec++;
      if (d !== 32'h0004_3210) begin n_err++; $display("FAIL dig_lo_rb got %h want 00043210", d); end
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(1, 40)) @(negedge i_clk);
         tt = t;
         e = 32'h0;
         e[3:0] = 4'((tt / 16) % 5);
         e[8] = tt[7];
         wb_read(5'h14, d);
         n_vec++;
         if (d !== e) begin n_err++; $display("FAIL status t=%0d got %h want %h", tt, d, e); end
      end
   endtask

   task automatic test_brightness();
      wb_write(5'h00, 32'h0000_0031, 4'hF);
      wb_write(5'h04, 32'h0000_0004, 4'hF);
      b_ctrl = 8'h31; b_en = 16'h0004;
      align_frame();
      lit_cyc = 0;
      observe(80);
      n_vec++;
      if (lit_cyc != 4) begin n_err++; $display("FAIL bright_duty got %0d lit cycles want 4", lit_cyc); end
   endtask

   task automatic test_frame_sync();
      wb_write(5'h00, 32'h0000_00F1, 4'hF);
      wb_write(5'h04, 32'h0000_001F, 4'hF);
      b_ctrl = 8'hF1; b_en = 16'h1F;
      align_frame();
      fork
         begin
            repeat (30) @(negedge i_clk);
            wb_write(5'h08, 32'h000A_BCDE, 4'hF);
         end
         begin
            observe(80);
            b_dig = 20'hABCDE;
            observe(80);
         end
      join
      wb_write(5'h00, 32'h0000_00F3, 4'hF);
      b_ctrl = 8'hF3;
      wb_write(5'h08, 32'h0001_2345, 4'hF);
      b_dig = 20'h12345;
      observe(32);
   endtask

   task automatic test_decode();
      wb_write(5'h00, 32'h0000_00F3, 4'hF);
      b_ctrl = 8'hF3; b_en = 16'h0001; b_dp = 16'h0; b_blk = 16'h0;
      for (int x = 0; x < 2; x++) begin
         wb_write(5'h04, (x == 1) ? 32'h0001_0001 : 32'h0000_0001, 4'hF);
         b_ext = (x == 1) ? 16'h0001 : 16'h0000;
         for (int v = 0; v < 16; v++) begin
            wb_write(5'h08, 32'(v), 4'hF);
            b_dig = 20'(v);
            observe(80);
         end
      end
   endtask

   task automatic test_ext_blink();
      wb_write(5'h00, 32'h0000_00F9, 4'hF);
      wb_write(5'h04, 32'h0001_0001, 4'hF);
      wb_write(5'h08, 32'h0000_0007, 4'hF);
      wb_write(5'h10, 32'h0001_0001, 4'hF);
      b_ctrl = 8'hF9; b_en = 16'h1; b_ext = 16'h1; b_dig = 20'h7; b_dp = 16'h1; b_blk = 16'h1;
      align_frame();
      observe(320);
   endtask

   task automatic test_irq();
      logic [31:0] d;
      wb_write(5'h00, 32'h0000_0005, 4'hF);
      wb_write(5'h04, 32'h0, 4'hF);
      wb_write(5'h10, 32'h0, 4'hF);
      model_clear();
      b_ctrl = 8'h05;
      align_frame();
      irq_cnt = 0;
      observe(240);
      n_vec++;
      if (irq_cnt != 3) begin n_err++; $display("FAIL irq_count got %0d want 3", irq_cnt); end
      wb_write(5'h0C, 32'hFFFF_FFFF, 4'hF);
      wb_read(5'h0C, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL dig_hi_rb got %h want 0", d); end
      wb_write(5'h18, 32'hFFFF_FFFF, 4'hF);
      wb_read(5'h18, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rb got %h want 0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wb_write(5'h00, 32'h0000_00F5, 4'hF);
      wb_write(5'h04, 32'h0000_001F, 4'hF);
      wb_write(5'h08, 32'h0004_3210, 4'hF);
      repeat (117) @(negedge i_clk);
      i_wb_adr = 5'h00; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
      i_rst = 1'b1;
      @(negedge i_clk);
      n_vec++;
      if ({o_an, o_seg, o_dp, o_frame_irq, o_wb_ack} !== {5'h1F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_reset got an=%h seg=%h dp=%b irq=%b ack=%b want 1f/7f/1/0/0",
                  o_an, o_seg, o_dp, o_frame_irq, o_wb_ack);
      end
      i_rst = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      model_clear();
      @(negedge i_clk);
      wb_read(5'h14, d);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL mid_reset_status got %h want 0", d); end
      for (int i = 0; i < 5; i++) begin
         wb_read(REG_ADR[i], d);
         n_vec++;
         if (d !== 32'h0) begin n_err++; $display("FAIL mid_reset_reg adr=%h got %h want 0", REG_ADR[i], d); end
      end
      observe(80);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no end of run want $finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst = 1'b1;
      i_wb_adr = 5'h0; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
      i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      model_clear();
      @(negedge i_clk);
      test_reset();
      test_regs();
      test_scan();
      test_brightness();
      test_frame_sync();
      test_decode();
      test_ext_blink();
      test_irq();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
